axis_tx_arbiter: RTL

AXIS_TX_ARBITER -- requirements
Module: axis_tx_arbiter

---
 rtl/axis_arb_pkg.sv | 25 ++
 rtl/axis_rr_picker.sv | 35 +++
 rtl/axis_tx_arbiter.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/axis_arb_pkg.sv
// Shared types and constants for the AXI-Stream transmit arbiter.
// Optional feature macro used by the top level: AXIS_ARB_PKT_CNT_EN.
package axis_arb_pkg;

  // Side-band widths carried unchanged from the winning port to the output.
  localparam int TUSER_W = 2;
  localparam int TDEST_W = 8;

  // Arbiter FSM: IDLE picks a winner, XFER routes one packet from it.
  typedef enum logic [0:0] {
    ARB_IDLE = 1'b0,
    ARB_XFER = 1'b1
  } arb_state_e;

  // Plain constants for the state register, kept equal to the enum values.
  localparam logic [0:0] ST_IDLE = 1'(ARB_IDLE);
  localparam logic [0:0] ST_XFER = 1'(ARB_XFER);

  // Round-robin rank of a port: 0 for the port right after the last grant,
  // NUM_PORTS-1 for the last granted port itself. Lowest rank wins.
  function automatic int rr_rank(input int port, input int last, input int n);
    return (port - last - 1 + n) % n;
  endfunction

endpackage

// File: rtl/axis_rr_picker.sv
// Combinational round-robin picker: given the request vector and the last
// granted index, returns the next requester (one-hot and binary index).
module axis_rr_picker
  import axis_arb_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int IDX_W     = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [IDX_W-1:0]     last,
  output logic [NUM_PORTS-1:0] onehot,
  output logic [IDX_W-1:0]     idx,
  output logic                 valid
);

  int best_rank;

  // Pick the requester with the lowest rank relative to the last grant.
  always_comb begin
    best_rank = NUM_PORTS;
    idx       = '0;
    onehot    = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (req[p] && (rr_rank(p, int'(last), NUM_PORTS) < best_rank)) begin
        best_rank = rr_rank(p, int'(last), NUM_PORTS);
        idx       = IDX_W'(p);
      end
    end
    valid = (best_rank < NUM_PORTS);
    for (int p = 0; p < NUM_PORTS; p++) begin
      onehot[p] = valid && (idx == IDX_W'(p));
    end
  end

endmodule

// File: rtl/axis_tx_arbiter.sv
// Packet-level round-robin arbiter merging NUM_PORTS AXI-Stream sources onto
// one transmit stream. A grant is held from the first beat to TLAST; one idle
// cycle separates packets.
// Optional feature: define AXIS_ARB_PKT_CNT_EN to add per-port 16-bit
// completed-packet counters on PKT_CNT.
//
// Handshake: a beat moves on a port when its TVALID and TREADY are both high
// on a rising ACLK edge; TVALID never waits on TREADY, and TREADY of a
// non-granted port is always low.
module axis_tx_arbiter
  import axis_arb_pkg::*;
#(
  parameter int NUM_PORTS  = 4,
  parameter int DATA_WIDTH = 16,
  parameter int ID_WIDTH   = 8
) (
  input  logic                              ACLK,
  input  logic                              ARESETn,
  input  logic [NUM_PORTS-1:0]              S_TVALID,
  output logic [NUM_PORTS-1:0]              S_TREADY,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]   S_TDATA,
  input  logic [NUM_PORTS*DATA_WIDTH/8-1:0] S_TKEEP,
  input  logic [NUM_PORTS*DATA_WIDTH/8-1:0] S_TSTRB,
  input  logic [NUM_PORTS-1:0]              S_TLAST,
  input  logic [NUM_PORTS*TUSER_W-1:0]      S_TUSER,
  input  logic [NUM_PORTS*TDEST_W-1:0]      S_TDEST,
  output logic                              M_TVALID,
  input  logic                              M_TREADY,
  output logic [DATA_WIDTH-1:0]             M_TDATA,
  output logic [DATA_WIDTH/8-1:0]           M_TKEEP,
  output logic [DATA_WIDTH/8-1:0]           M_TSTRB,
  output logic                              M_TLAST,
  output logic [TUSER_W-1:0]                M_TUSER,
  output logic [TDEST_W-1:0]                M_TDEST,
  output logic [ID_WIDTH-1:0]               M_TID,
  output logic [NUM_PORTS-1:0]              GRANT,
  output logic [0:0]                        state_dbg
`ifdef AXIS_ARB_PKT_CNT_EN
  ,
  output logic [NUM_PORTS*16-1:0]           PKT_CNT
`endif
);

  localparam int IDX_W  = $clog2(NUM_PORTS);
  localparam int KEEP_W = DATA_WIDTH / 8;

  logic [0:0]           state;
  logic [IDX_W-1:0]     grant_idx;
  logic [NUM_PORTS-1:0] grant_q;
  logic [IDX_W-1:0]     last_grant;
  logic [NUM_PORTS-1:0] pick_onehot;
  logic [IDX_W-1:0]     pick_idx;
  logic                 pick_valid;
  logic                 xfer;
  logic                 pkt_done;

  axis_rr_picker #(
    .NUM_PORTS (NUM_PORTS),
    .IDX_W     (IDX_W)
  ) u_picker (
    .req    (S_TVALID),
    .last   (last_grant),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .valid  (pick_valid)
  );

  assign xfer      = (state == ST_XFER);
  assign pkt_done  = xfer && M_TVALID && M_TREADY && M_TLAST;
  assign state_dbg = state;

  // FSM: latch the winner in IDLE, release it on the TLAST handshake.
  // last_grant resets to the top port so that port 0 is searched first.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state      <= ST_IDLE;
      grant_idx  <= '0;
      grant_q    <= '0;
      last_grant <= IDX_W'(NUM_PORTS - 1);
    end else if (state == ST_IDLE) begin
      if (pick_valid) begin
        state     <= ST_XFER;
        grant_idx <= pick_idx;
        grant_q   <= pick_onehot;
      end
    end else begin
      if (pkt_done) begin
        state      <= ST_IDLE;
        last_grant <= grant_idx;
      end
    end
  end

  // Route the granted port's payload; nothing is modified on the way through.
  always_comb begin
    M_TDATA = '0;
    M_TKEEP = '0;
    M_TSTRB = '0;
    M_TLAST = 1'b0;
    M_TUSER = '0;
    M_TDEST = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (grant_idx == IDX_W'(p)) begin
        M_TDATA = S_TDATA[p*DATA_WIDTH +: DATA_WIDTH];
        M_TKEEP = S_TKEEP[p*KEEP_W +: KEEP_W];
        M_TSTRB = S_TSTRB[p*KEEP_W +: KEEP_W];
        M_TLAST = S_TLAST[p];
        M_TUSER = S_TUSER[p*TUSER_W +: TUSER_W];
        M_TDEST = S_TDEST[p*TDEST_W +: TDEST_W];
      end
    end
  end

  // Handshake outputs exist only in XFER; idle leaves every ready and valid low.
  always_comb begin
    GRANT    = xfer ? grant_q : '0;
    S_TREADY = GRANT & {NUM_PORTS{M_TREADY}};
    M_TVALID = xfer && |(grant_q & S_TVALID);
    M_TID    = ID_WIDTH'(grant_idx);
  end

`ifdef AXIS_ARB_PKT_CNT_EN
  logic [15:0] pkt_cnt [NUM_PORTS];

  // Count completed packets per port; 16-bit counters wrap naturally.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      for (int p = 0; p < NUM_PORTS; p++) pkt_cnt[p] <= '0;
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (pkt_done && (grant_idx == IDX_W'(p))) pkt_cnt[p] <= pkt_cnt[p] + 16'd1;
      end
    end
  end

  // Flatten the counters onto the output bus, port p at [p*16 +: 16].
  always_comb begin
    PKT_CNT = '0;
    for (int p = 0; p < NUM_PORTS; p++) PKT_CNT[p*16 +: 16] = pkt_cnt[p];
  end
`endif

endmodule
